muldiv_unit: RTL

- Iterative MIPS multiply/divide unit with architectural HI/LO registers, one stage downstream of the register file.
- Consumes the two register-file read ports (rs/rt contents) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the writeback mux for MFHI/MFLO.
- Control stalls the pipeline while busy is high.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and two's-complement helpers for the MIPS
// multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PROD_W = 2 * DEF_DATA_W;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Conditional two's-complement negation: magnitude extraction and sign fix-up.
    function automatic logic [DEF_DATA_W-1:0] cond_neg_w(input logic [DEF_DATA_W-1:0] v,
                                                         input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [DEF_PROD_W-1:0] cond_neg_p(input logic [DEF_PROD_W-1:0] v,
                                                         input logic en);
        return en ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide with architectural HI/LO; one bit per cycle,
// DATA_W iterations plus one sign-fix cycle, new HI/LO and done two cycles later.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] rs_raw_q, rs_raw_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic              is_div_q, is_div_d;
    logic              done_q, done_d;

    logic              op_signed;
    logic              sign_diff;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign rs_mag    = cond_neg_w(rs_data, op_signed & rs_data[DATA_W-1]);
    assign rt_mag    = cond_neg_w(rt_data, op_signed & rt_data[DATA_W-1]);
    assign sign_diff = op_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);

    // Multiply: upper half accumulates, lower half holds the unconsumed multiplier bits.
    logic [DATA_W:0]   mul_sum;
    logic [PROD_W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[PROD_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out
    // and quotient in. Since remainder < 2*divisor, the borrow bit alone decides.
    logic [DATA_W:0]   div_shift, div_sub;
    logic              div_ge;
    logic [PROD_W-1:0] div_next;

    assign div_shift = {acc_q[PROD_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_sub   = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_sub[DATA_W];
    assign div_next  = {(div_ge ? div_sub[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                        acc_q[DATA_W-2:0], div_ge};

    logic [PROD_W-1:0] prod_fix;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    assign prod_fix = cond_neg_p(acc_q, neg_res_q);
    assign quo_fix  = cond_neg_w(acc_q[DATA_W-1:0], neg_res_q);
    assign rem_fix  = cond_neg_w(acc_q[PROD_W-1:DATA_W], neg_rem_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rs_raw_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            rs_raw_q  <= rs_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rs_raw_d  = rs_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {{DATA_W{1'b0}}, rt_mag};
                            opnd_d    = rs_mag;
                            neg_res_d = sign_diff;
                            is_div_d  = 1'b0;
                            cnt_d     = CNT_W'(DATA_W - 1);
                            state_d   = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d     = {{DATA_W{1'b0}}, rs_mag};
                            opnd_d    = rt_mag;
                            rs_raw_d  = rs_data;
                            neg_res_d = sign_diff;
                            neg_rem_d = op_signed & rs_data[DATA_W-1];
                            div0_d    = (rt_data == '0);
                            is_div_d  = 1'b1;
                            cnt_d     = CNT_W'(DATA_W - 1);
                            state_d   = ST_DIV;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d = mul_next;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                acc_d = div_next;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[PROD_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end else if (div0_q) begin
                    hi_d = rs_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
